// File: rtl/bitstream_serializer_if.sv
// Word-in / bit-out handshake bundle for bitstream_serializer.
// The master drives words in and observes the serial stream; the slave is the serializer.
interface bitstream_serializer_if #(
    parameter int W = 4
) ();
    logic [W-1:0] data_in;
    logic         data_valid;
    logic         data_ready;
    logic         ser_out;
    logic         ser_valid;
    logic         busy;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready,
        input  ser_out,
        input  ser_valid,
        input  busy
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready,
        output ser_out,
        output ser_valid,
        output busy
    );
endinterface

// File: rtl/bitstream_serializer.sv
// Parallel-in/serial-out stage: words are queued in a circular FIFO and shifted out MSB-first
// on a registered serial line, back-to-back words streaming without gap bits.
module bitstream_serializer #(
    parameter int   W        = 4,
    parameter int   DEPTH    = 4,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    bitstream_serializer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = (W > 2) ? $clog2(W) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t         state_r;
    state_t         state_n;
    logic [W-1:0]   mem_r [DEPTH];
    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [CW-1:0]  count_r;
    logic [W-1:0]   shreg_r;
    logic [W-1:0]   shreg_n;
    logic [BW-1:0]  bit_cnt_r;
    logic [BW-1:0]  bit_cnt_n;
    logic           ser_out_r;
    logic           ser_out_n;
    logic           ser_valid_r;
    logic           ser_valid_n;
    logic           data_ready_s;
    logic           push_s;
    logic           pop_s;
    logic           fifo_empty_s;
    logic [W-1:0]   head_s;

    // No full-bypass: a pop in the same cycle does not open the door for a push.
    assign data_ready_s = (count_r != CW'(DEPTH));
    assign push_s       = bus.data_valid && data_ready_s;
    assign fifo_empty_s = (count_r == {CW{1'b0}});
    assign head_s       = mem_r[rd_ptr_r];

    // FIFO storage, pointers and occupancy count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= bus.data_in;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Shifter state, shift register, bit counter and registered serial outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            shreg_r     <= {W{1'b0}};
            bit_cnt_r   <= {BW{1'b0}};
            ser_out_r   <= IDLE_BIT;
            ser_valid_r <= 1'b0;
        end else begin
            state_r     <= state_n;
            shreg_r     <= shreg_n;
            bit_cnt_r   <= bit_cnt_n;
            ser_out_r   <= ser_out_n;
            ser_valid_r <= ser_valid_n;
        end
    end

    // Next-state logic; ser_out_n always mirrors the MSB of shreg_n while a word is live
    always_comb begin
        state_n     = state_r;
        shreg_n     = shreg_r;
        bit_cnt_n   = bit_cnt_r;
        ser_out_n   = ser_out_r;
        ser_valid_n = ser_valid_r;
        pop_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s       = 1'b1;
                    shreg_n     = head_s;
                    bit_cnt_n   = BW'(W - 1);
                    ser_out_n   = head_s[W-1];
                    ser_valid_n = 1'b1;
                    state_n     = SHIFT;
                end else begin
                    ser_out_n   = IDLE_BIT;
                    ser_valid_n = 1'b0;
                end
            end
            SHIFT: begin
                if (bit_cnt_r != {BW{1'b0}}) begin
                    shreg_n     = {shreg_r[W-2:0], 1'b0};
                    bit_cnt_n   = bit_cnt_r - BW'(1);
                    ser_out_n   = shreg_r[W-2];
                    ser_valid_n = 1'b1;
                end else if (!fifo_empty_s) begin
                    // Seamless reload on the last-bit edge keeps the stream gap-free.
                    pop_s       = 1'b1;
                    shreg_n     = head_s;
                    bit_cnt_n   = BW'(W - 1);
                    ser_out_n   = head_s[W-1];
                    ser_valid_n = 1'b1;
                end else begin
                    ser_out_n   = IDLE_BIT;
                    ser_valid_n = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: begin
                state_n     = IDLE;
                ser_out_n   = IDLE_BIT;
                ser_valid_n = 1'b0;
            end
        endcase
    end

    assign bus.data_ready = data_ready_s;
    assign bus.ser_out    = ser_out_r;
    assign bus.ser_valid  = ser_valid_r;
    assign bus.busy       = (state_r == SHIFT) || !fifo_empty_s;

endmodule

// File: tb/tb_bitstream_serializer.sv
// Directed self-checking bench for bitstream_serializer (W=4, DEPTH=4, IDLE_BIT=0).
module tb_bitstream_serializer;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    // Serial-stream monitor state (written only by the monitor process)
    logic [63:0] mon_bits;
    int          mon_nbits;
    int          mon_runs;
    logic        mon_prev;

    bitstream_serializer_if #(.W(4)) bus ();

    bitstream_serializer #(.W(4), .DEPTH(4), .IDLE_BIT(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Collect valid serial bits and count contiguous valid runs, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            mon_prev <= 1'b0;
        end else begin
            if (bus.ser_valid) begin
                mon_bits  <= {mon_bits[62:0], bus.ser_out};
                mon_nbits <= mon_nbits + 1;
                if (!mon_prev) mon_runs <= mon_runs + 1;
            end
            mon_prev <= bus.ser_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 200) begin
            tick();
            n++;
        end
        chk("idle_timeout", 64'(bus.busy), 64'd0);
    endtask

    task automatic push_when_ready(input logic [3:0] w);
        int n;
        bus.data_in    = w;
        bus.data_valid = 1'b1;
        n = 0;
        while (!bus.data_ready && n < 100) begin
            tick();
            n++;
        end
        chk("push_timeout", 64'(bus.data_ready), 64'd1);
        tick();
        bus.data_valid = 1'b0;
    endtask

    initial begin
        logic [3:0] w;
        int base_n;
        int base_r;

        checks = 0;
        failures = 0;
        mon_bits = 64'd0;
        mon_nbits = 0;
        mon_runs = 0;
        mon_prev = 1'b0;
        rst = 1'b1;
        bus.data_in = 4'h0;
        bus.data_valid = 1'b0;

        // Reset state, with a word offered during reset that must be ignored
        #1;
        chk("rst_ser_out", 64'(bus.ser_out), 64'd0);
        chk("rst_ser_valid", 64'(bus.ser_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_ready", 64'(bus.data_ready), 64'd1);
        bus.data_in = 4'hF;
        bus.data_valid = 1'b1;
        tick();
        tick();
        bus.data_valid = 1'b0;
        rst = 1'b0;
        chk("rst_no_push", 64'(bus.busy), 64'd0);

        // Single word: one-cycle FIFO latency, then 4 MSB-first bits
        w = 4'b1001;
        bus.data_in = w;
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
        chk("single_queued_busy", 64'(bus.busy), 64'd1);
        chk("single_no_bypass", 64'(bus.ser_valid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("single_valid", 64'(bus.ser_valid), 64'd1);
            chk("single_bit", 64'(bus.ser_out), 64'(w[3-i]));
        end
        tick();
        chk("single_end_valid", 64'(bus.ser_valid), 64'd0);
        chk("single_end_out", 64'(bus.ser_out), 64'd0);
        chk("single_end_busy", 64'(bus.busy), 64'd0);

        // Back-to-back: 8 contiguous bits, one valid run
        base_n = mon_nbits;
        base_r = mon_runs;
        bus.data_in = 4'b1001;
        bus.data_valid = 1'b1;
        tick();
        bus.data_in = 4'b0010;
        tick();
        bus.data_valid = 1'b0;
        wait_idle();
        tick();
        chk("b2b_nbits", 64'(mon_nbits - base_n), 64'd8);
        chk("b2b_bits", 64'(mon_bits[7:0]), 64'h92);
        chk("b2b_runs", 64'(mon_runs - base_r), 64'd1);

        // Backpressure: shifter busy, FIFO fills, held word accepted after the next pop
        base_n = mon_nbits;
        base_r = mon_runs;
        bus.data_valid = 1'b1;
        bus.data_in = 4'h3; tick();
        bus.data_in = 4'h5; tick();
        bus.data_in = 4'h6; tick();
        bus.data_in = 4'h9; tick();
        bus.data_in = 4'hC; tick();
        chk("bp_full_ready", 64'(bus.data_ready), 64'd0);
        bus.data_in = 4'h7; tick();
        chk("bp_ready_after_pop", 64'(bus.data_ready), 64'd1);
        tick();
        chk("bp_full_again", 64'(bus.data_ready), 64'd0);
        bus.data_valid = 1'b0;
        wait_idle();
        tick();
        chk("bp_nbits", 64'(mon_nbits - base_n), 64'd24);
        chk("bp_bits", 64'(mon_bits[23:0]), 64'h3569C7);
        chk("bp_runs", 64'(mon_runs - base_r), 64'd1);

        // Pointer wrap: 10 words through a 4-deep FIFO stay in order
        base_n = mon_nbits;
        base_r = mon_runs;
        for (int i = 1; i <= 10; i++) begin
            push_when_ready(4'(i));
        end
        wait_idle();
        tick();
        chk("wrap_nbits", 64'(mon_nbits - base_n), 64'd40);
        chk("wrap_bits", 64'(mon_bits[39:0]), 64'h123456789A);
        chk("wrap_runs", 64'(mon_runs - base_r), 64'd1);

        // Reset mid-word: 1011 has shown 2 bits, two more words queued
        bus.data_valid = 1'b1;
        bus.data_in = 4'b1011; tick();
        bus.data_in = 4'hF; tick();
        chk("mid_bit3", 64'(bus.ser_out), 64'd1);
        bus.data_in = 4'hE; tick();
        chk("mid_bit2", 64'(bus.ser_out), 64'd0);
        bus.data_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ser_out", 64'(bus.ser_out), 64'd0);
        chk("arst_ser_valid", 64'(bus.ser_valid), 64'd0);
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_ready", 64'(bus.data_ready), 64'd1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        base_n = mon_nbits;

        // Handshake idle: nothing stale, nothing spontaneous for 20 cycles
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_ser_valid", 64'(bus.ser_valid), 64'd0);
            chk("idle_ser_out", 64'(bus.ser_out), 64'd0);
        end
        chk("idle_busy", 64'(bus.busy), 64'd0);
        chk("idle_ready", 64'(bus.data_ready), 64'd1);
        chk("idle_no_bits", 64'(mon_nbits - base_n), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
